// File: rtl/smart_toilet_dispense_ctrl.sv
// Reagent dispense sequencer: meters soln3, soln2, then soln1 pumps, waits a settle
// interval, opens the drain valve, then reports completion with a status code.
module smart_toilet_dispense_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_vol1,
  input  logic [CNT_W-1:0] cmd_vol2,
  input  logic [CNT_W-1:0] cmd_vol3,
  input  logic [CNT_W-1:0] cmd_settle,
  input  logic             abort,
  output logic [2:0]       pump_en,
  output logic             valve_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status
);

  typedef enum logic [2:0] {IDLE, DISP3, DISP2, DISP1, SETTLE, DRAIN, DONE} state_e;

  localparam logic [1:0]       ST_OK      = 2'b00;
  localparam logic [1:0]       ST_ABORT   = 2'b01;
  localparam logic [1:0]       ST_EMPTY   = 2'b10;
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

  state_e           state_q, state_d, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] vol1_q, vol1_d, vol2_q, vol2_d, settle_q, settle_d;
  logic [2:0]       pump_q, pump_d;
  logic             valve_q, valve_d, done_q, done_d, enter;
  logic [1:0]       status_q, status_d;

  // Next phase after cur, skipping every phase whose length is zero.
  function automatic state_e next_phase(input state_e cur, input logic [CNT_W-1:0] v3,
                                        input logic [CNT_W-1:0] v2, input logic [CNT_W-1:0] v1,
                                        input logic [CNT_W-1:0] s);
    state_e r;
    r = DRAIN;
    if (cur != SETTLE && s != '0) r = SETTLE;
    if ((cur == IDLE || cur == DISP3 || cur == DISP2) && v1 != '0) r = DISP1;
    if ((cur == IDLE || cur == DISP3) && v2 != '0) r = DISP2;
    if (cur == IDLE && v3 != '0) r = DISP3;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] phase_len(input state_e st, input logic [CNT_W-1:0] v3,
                                                 input logic [CNT_W-1:0] v2, input logic [CNT_W-1:0] v1,
                                                 input logic [CNT_W-1:0] s);
    logic [CNT_W-1:0] r;
    case (st)
      DISP3:   r = v3;
      DISP2:   r = v2;
      DISP1:   r = v1;
      SETTLE:  r = s;
      default: r = DRAIN_LOAD;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vol1_d   = vol1_q;
    vol2_d   = vol2_q;
    settle_d = settle_q;
    pump_d   = pump_q;
    valve_d  = valve_q;
    done_d   = 1'b0;
    status_d = ST_OK;
    enter    = 1'b0;
    nxt      = IDLE;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          vol1_d   = cmd_vol1;
          vol2_d   = cmd_vol2;
          settle_d = cmd_settle;
          if (cmd_vol1 == '0 && cmd_vol2 == '0 && cmd_vol3 == '0) begin
            state_d  = DONE;
            done_d   = 1'b1;
            status_d = ST_EMPTY;
          end else begin
            enter = 1'b1;
            nxt   = next_phase(IDLE, cmd_vol3, cmd_vol2, cmd_vol1, cmd_settle);
          end
        end
      end
      DISP3, DISP2, DISP1, SETTLE, DRAIN: begin
        if (abort) begin
          state_d  = DONE;
          done_d   = 1'b1;
          status_d = ST_ABORT;
          pump_d   = 3'b000;
          valve_d  = 1'b0;
        end else if (cnt_q == ONE) begin
          if (state_q == DRAIN) begin
            state_d = DONE;
            done_d  = 1'b1;
            valve_d = 1'b0;
          end else begin
            enter = 1'b1;
            nxt   = next_phase(state_q, '0, vol2_q, vol1_q, settle_q);
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Phase entry: load the phase length and set the matching registered outputs.
    if (enter) begin
      state_d = nxt;
      cnt_d   = phase_len(nxt, cmd_vol3, vol2_d, vol1_d, settle_d);
      valve_d = (nxt == DRAIN);
      case (nxt)
        DISP3:   pump_d = 3'b100;
        DISP2:   pump_d = 3'b010;
        DISP1:   pump_d = 3'b001;
        default: pump_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    vol1_q   <= vol1_d;
    vol2_q   <= vol2_d;
    settle_q <= settle_d;
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pump_q   <= 3'b000;
      valve_q  <= 1'b0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pump_q   <= pump_d;
      valve_q  <= valve_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign pump_en   = pump_q;
  assign valve_out = valve_q;
  assign done      = done_q;
  assign status    = status_q;

endmodule

// File: tb/tb_smart_toilet_dispense_ctrl.sv
// Randomized and directed bench for smart_toilet_dispense_ctrl against a per-cycle
// expected-trace model built from phase lengths.
module tb_smart_toilet_dispense_ctrl;
  localparam int CNT_W = 16;
  localparam int DRAIN = 4;

  logic             clk = 1'b0;
  logic             rst, cmd_valid, abort;
  logic [CNT_W-1:0] cmd_vol1, cmd_vol2, cmd_vol3, cmd_settle;
  logic             cmd_ready, valve_out, busy, done;
  logic [2:0]       pump_en;
  logic [1:0]       status;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs;

  smart_toilet_dispense_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vol1(cmd_vol1), .cmd_vol2(cmd_vol2), .cmd_vol3(cmd_vol3), .cmd_settle(cmd_settle),
    .abort(abort), .pump_en(pump_en), .valve_out(valve_out), .busy(busy),
    .done(done), .status(status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {busy, pump_en, valve_out, done, status} for cycles E+1, E+2, ...
  function automatic void build_model(input int v1, input int v2, input int v3, input int s,
                                      input int abort_k);
    exp_q.delete();
    if (v1 == 0 && v2 == 0 && v3 == 0) begin
      exp_q.push_back({1'b1, 3'b000, 1'b0, 1'b1, 2'b10});
    end else begin
      repeat (v3) exp_q.push_back({1'b1, 3'b100, 1'b0, 1'b0, 2'b00});
      repeat (v2) exp_q.push_back({1'b1, 3'b010, 1'b0, 1'b0, 2'b00});
      repeat (v1) exp_q.push_back({1'b1, 3'b001, 1'b0, 1'b0, 2'b00});
      repeat (s) exp_q.push_back({1'b1, 3'b000, 1'b0, 1'b0, 2'b00});
      repeat (DRAIN) exp_q.push_back({1'b1, 3'b000, 1'b1, 1'b0, 2'b00});
      exp_q.push_back({1'b1, 3'b000, 1'b0, 1'b1, 2'b00});
    end
    if (abort_k > 0 && abort_k < exp_q.size()) begin
      while (exp_q.size() > abort_k) void'(exp_q.pop_back());
      exp_q.push_back({1'b1, 3'b000, 1'b0, 1'b1, 2'b01});
    end
  endfunction

  task automatic offer(input int v1, input int v2, input int v3, input int s, input logic ab);
    cmd_vol1 = CNT_W'(v1); cmd_vol2 = CNT_W'(v2); cmd_vol3 = CNT_W'(v3); cmd_settle = CNT_W'(s);
    cmd_valid = 1'b1;
    abort = ab;
    tick();
    cmd_valid = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; abort = 1'b0;
    cmd_valid = 1'b1; cmd_vol1 = 16'd3; cmd_vol2 = 16'd2; cmd_vol3 = 16'd1; cmd_settle = 16'd1;
    repeat (3) tick();
    checks++;
    if ({busy, pump_en, valve_out, done, status, cmd_ready} !== 9'b0_000_0_0_00_1) begin
      failures++;
      $display("FAIL reset_values got=%b exp=%b", {busy, pump_en, valve_out, done, status, cmd_ready}, 9'b000000001);
    end
    rst = 1'b0; cmd_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake_ignored busy=%b ready=%b exp busy=0 ready=1", busy, cmd_ready);
    end
  endtask

  task automatic test_directed();
    int tbl[3][4] = '{'{2, 3, 5, 4}, '{3, 0, 0, 0}, '{0, 0, 0, 5}};
    for (int t = 0; t < 3; t++) begin
      build_model(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3], 0);
      offer(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3], 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        obs = {busy, pump_en, valve_out, done, done ? status : 2'b00};
        checks++;
        if (obs !== exp_q[i]) begin
          failures++;
          $display("FAIL directed%0d cyc=E+%0d got=%b exp=%b", t, i + 1, obs, exp_q[i]);
        end
        tick();
      end
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL directed%0d_ready ready=%b busy=%b exp ready=1 busy=0", t, cmd_ready, busy);
      end
    end
  endtask

  task automatic test_abort();
    // vol3=2 so DISP2 spans E+3..E+12; its 3rd cycle is E+5
    build_model(2, 10, 2, 3, 5);
    offer(2, 10, 2, 3, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = {busy, pump_en, valve_out, done, done ? status : 2'b00};
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL abort cyc=E+%0d got=%b exp=%b", i + 1, obs, exp_q[i]);
      end
      if (i == 4) abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd_ready !== 1'b1 || valve_out !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL abort_after ready=%b valve=%b done=%b exp 1 0 0", cmd_ready, valve_out, done);
      end
      abort = (i == 1);
      tick();
      abort = 1'b0;
    end
  endtask

  task automatic test_reset_mid_drain();
    offer(1, 0, 0, 0, 1'b0);
    tick();
    checks++;
    if (valve_out !== 1'b1) begin
      failures++;
      $display("FAIL drain_open valve=%b exp=1", valve_out);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({valve_out, cmd_ready, busy, done, pump_en} !== 7'b0100_000) begin
      failures++;
      $display("FAIL reset_mid_drain got=%b exp=%b", {valve_out, cmd_ready, busy, done, pump_en}, 7'b0100000);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_done done=%b busy=%b exp 0 0", done, busy);
      end
    end
  endtask

  task automatic test_random();
    int v1, v2, v3, s, ak, len;
    logic ab_hs;
    for (int n = 0; n < 25; n++) begin
      v1 = $urandom_range(0, 4); v2 = $urandom_range(0, 4); v3 = $urandom_range(0, 4);
      s = $urandom_range(0, 3); ab_hs = 1'($urandom_range(0, 1));
      build_model(v1, v2, v3, s, 0);
      len = exp_q.size();
      ak = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
      build_model(v1, v2, v3, s, ak);
      offer(v1, v2, v3, s, ab_hs);
      for (int i = 0; i < exp_q.size(); i++) begin
        obs = {busy, pump_en, valve_out, done, done ? status : 2'b00};
        checks++;
        if (obs !== exp_q[i]) begin
          failures++;
          $display("FAIL random%0d cmd=%0d/%0d/%0d/%0d ab=%0d cyc=E+%0d got=%b exp=%b",
                   n, v3, v2, v1, s, ak, i + 1, obs, exp_q[i]);
        end
        if (i == ak - 1) abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL random%0d_ready ready=%b exp=1", n, cmd_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cmds[2][4] = '{'{2, 1, 3, 1}, '{1, 2, 0, 0}};
    cmd_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cmd_vol1 = CNT_W'(cmds[c][0]); cmd_vol2 = CNT_W'(cmds[c][1]);
      cmd_vol3 = CNT_W'(cmds[c][2]); cmd_settle = CNT_W'(cmds[c][3]);
      tick();
      if (c == 1) cmd_valid = 1'b0;
      else begin
        cmd_vol1 = CNT_W'(cmds[1][0]); cmd_vol2 = CNT_W'(cmds[1][1]);
        cmd_vol3 = CNT_W'(cmds[1][2]); cmd_settle = CNT_W'(cmds[1][3]);
      end
      build_model(cmds[c][0], cmds[c][1], cmds[c][2], cmds[c][3], 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        obs = {busy, pump_en, valve_out, done, done ? status : 2'b00};
        checks++;
        if (obs !== exp_q[i]) begin
          failures++;
          $display("FAIL b2b%0d cyc=E+%0d got=%b exp=%b", c, i + 1, obs, exp_q[i]);
        end
        tick();
      end
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL b2b%0d_ready ready=%b busy=%b exp ready=1 busy=0", c, cmd_ready, busy);
      end
    end
  endtask

  task automatic test_max_volume();
    int ones = 0, bad = 0, done_k = 0;
    logic [1:0] st = 2'b11;
    offer(65535, 0, 0, 0, 1'b0);
    for (int k = 1; k <= 70000; k++) begin
      if (pump_en == 3'b001) ones++;
      else if (pump_en != 3'b000) bad++;
      if (done === 1'b1) begin
        done_k = k; st = status;
        break;
      end
      tick();
    end
    tick();
    checks++;
    if (ones != 65535) begin
      failures++;
      $display("FAIL maxvol_pump_cycles got=%0d exp=65535", ones);
    end
    checks++;
    if (done_k != 65535 + DRAIN + 1 || st !== 2'b00 || bad != 0) begin
      failures++;
      $display("FAIL maxvol_done cyc=%0d status=%b bad=%0d exp cyc=%0d status=00 bad=0",
               done_k, st, bad, 65535 + DRAIN + 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid_drain();
    test_random();
    test_back_to_back();
    test_max_volume();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
